instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks a combinational instruction memory, holds one
// registered instruction for decode, and supports redirect, halt and resume.
module instr_fetch #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt_req,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  // Handshake: instr/instr_pc transfer to decode on every rising edge where
  // instr_valid && instr_ready; while valid && !ready they are held unchanged.

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_instr;
  logic [ADDR_W-1:0]   r_instr_pc;
  logic                r_valid;
  logic [15:0]         r_count;

  logic w_active;
  logic w_accept;
  logic w_load;
  logic w_flush;
  logic w_redirect_pc;
  logic w_halted;

  // A start pulse makes its own cycle a fetching cycle, so the first word
  // lands on instr one edge after start.
  assign w_active      = (r_state == S_RUN) || start;
  assign w_accept      = r_valid && instr_ready;
  assign w_load        = w_active && !redirect_valid && !halt_req && (!r_valid || instr_ready);
  assign w_flush       = w_active && redirect_valid;
  assign w_redirect_pc = redirect_valid && ((r_state != S_IDLE) || start);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_HALTED: begin
        if (start) w_next_state = halt_req ? S_HALTED : S_RUN;
      end
      S_RUN: begin
        if (halt_req) w_next_state = S_HALTED;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_halted = 1'b0;
    if (r_state == S_HALTED) w_halted = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_redirect_pc) begin
        r_pc <= redirect_target;
      end else if (w_load) begin
        r_pc <= r_pc + ADDR_W'(1);
      end

      if (w_load) begin
        r_instr    <= imem_data;
        r_instr_pc <= r_pc;
        r_valid    <= 1'b1;
      end else if (w_flush || w_accept) begin
        r_valid <= 1'b0;
      end

      // Accepted instruction is counted even when the same edge flushes.
      if (w_accept) r_count <= r_count + 16'd1;
    end
  end

  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = w_halted;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed stimulus, a rule-level reference model
// compared every cycle, plus literal expectations at key points.
module tb_instr_fetch;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          halt_req;
  logic          halted;
  logic [15:0]   fetch_count;

  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  assign imem_data = mem[imem_addr];

  // clock / memory init
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hE003 ^ DW'(i * 16'h0111);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: mode 0 = idle, 1 = fetching, 2 = halted
  bit          m_live = 0;
  int          m_mode;
  int          m_pc;
  logic [15:0] m_instr;
  int          m_ipc;
  bit          m_valid;
  logic [15:0] m_count;

  always @(posedge clk) begin
    bit acc;
    bit running;
    acc     = m_valid && instr_ready;
    running = (m_mode == 1) || start;
    if (reset) begin
      m_live  <= 1;
      m_mode  <= 0;
      m_pc    <= 0;
      m_instr <= '0;
      m_ipc   <= 0;
      m_valid <= 0;
      m_count <= '0;
    end else if (m_live) begin
      if (acc) m_count <= m_count + 16'd1;
      if (running) begin
        if (halt_req) begin
          m_mode <= 2;
          if (redirect_valid) begin
            m_pc    <= int'(redirect_target);
            m_valid <= 0;
          end else if (acc) begin
            m_valid <= 0;
          end
        end else if (redirect_valid) begin
          m_mode  <= 1;
          m_pc    <= int'(redirect_target);
          m_valid <= 0;
        end else if (!m_valid || instr_ready) begin
          m_mode  <= 1;
          m_instr <= mem[m_pc];
          m_ipc   <= m_pc;
          m_valid <= 1;
          m_pc    <= (m_pc + 1) % DEPTH;
        end else begin
          m_mode <= 1;
        end
      end else begin
        if (acc) m_valid <= 0;
        if (m_mode == 2 && redirect_valid) m_pc <= int'(redirect_target);
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (m_live) begin
      check("model_valid", 32'(instr_valid), 32'(m_valid));
      check("model_halted", 32'(halted), 32'(m_mode == 2));
      check("model_count", 32'(fetch_count), 32'(m_count));
      check("model_imem_addr", 32'(imem_addr), 32'(m_pc));
      if (m_valid) begin
        check("model_instr", 32'(instr), 32'(m_instr));
        check("model_instr_pc", 32'(instr_pc), 32'(m_ipc));
      end
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1; start = 0; instr_ready = 0;
    redirect_valid = 0; redirect_target = '0; halt_req = 0;
    @(negedge clk);
    tick(2);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);

    // first fetch
    reset = 0; instr_ready = 1; start = 1;
    tick();
    start = 0;
    check("first_instr", 32'(instr), 32'hE003);
    check("first_pc", 32'(instr_pc), 32'd0);
    check("first_valid", 32'(instr_valid), 32'd1);
    tick();
    check("second_pc", 32'(instr_pc), 32'd1);
    check("second_count", 32'(fetch_count), 32'd1);

    // backpressure at instr_pc 5
    tick(4);
    check("bp_pc_reached", 32'(instr_pc), 32'd5);
    instr_ready = 0;
    tick(3);
    check("bp_pc_held", 32'(instr_pc), 32'd5);
    check("bp_instr_held", 32'(instr), 32'(mem[5]));
    check("bp_addr", 32'(imem_addr), 32'd6);
    check("bp_count", 32'(fetch_count), 32'd5);
    instr_ready = 1;
    tick();
    check("bp_release_pc", 32'(instr_pc), 32'd6);

    // redirect while instr_pc 8 is accepted
    tick(2);
    check("rd_pc8", 32'(instr_pc), 32'd8);
    redirect_valid = 1; redirect_target = 6'd16;
    tick();
    redirect_valid = 0;
    check("rd_flush_valid", 32'(instr_valid), 32'd0);
    check("rd_count", 32'(fetch_count), 32'd9);
    tick();
    check("rd_target_pc", 32'(instr_pc), 32'd16);

    // wrap through 63
    redirect_valid = 1; redirect_target = 6'd63;
    tick();
    redirect_valid = 0;
    tick();
    check("wrap_63", 32'(instr_pc), 32'd63);
    tick();
    check("wrap_0", 32'(instr_pc), 32'd0);
    tick();
    check("wrap_1", 32'(instr_pc), 32'd1);

    // halt with a live instruction under backpressure
    halt_req = 1; instr_ready = 0;
    tick();
    halt_req = 0;
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_keep_valid", 32'(instr_valid), 32'd1);
    tick();
    check("halt_keep_pc", 32'(instr_pc), 32'd1);
    instr_ready = 1;
    tick();
    check("halt_drop_valid", 32'(instr_valid), 32'd0);
    check("halt_pc_held", 32'(imem_addr), 32'd2);
    tick(2);
    start = 1;
    tick();
    start = 0;
    check("resume_pc", 32'(instr_pc), 32'd2);
    check("resume_unhalted", 32'(halted), 32'd0);

    // redirect and halt together, then redirect while halted
    redirect_valid = 1; halt_req = 1; redirect_target = 6'd40;
    tick();
    redirect_valid = 0; halt_req = 0;
    check("rh_halted", 32'(halted), 32'd1);
    check("rh_addr", 32'(imem_addr), 32'd40);
    tick();
    redirect_valid = 1; redirect_target = 6'd50;
    tick();
    redirect_valid = 0;
    check("hr_addr", 32'(imem_addr), 32'd50);
    check("hr_still_halted", 32'(halted), 32'd1);
    start = 1;
    tick();
    start = 0;
    check("hr_resume_pc", 32'(instr_pc), 32'd50);

    // reset in the middle of a run
    tick(3);
    reset = 1;
    tick();
    reset = 0;
    check("mr_valid", 32'(instr_valid), 32'd0);
    check("mr_count", 32'(fetch_count), 32'd0);
    check("mr_addr", 32'(imem_addr), 32'd0);
    check("mr_instr", 32'(instr), 32'd0);
    tick(2);
    check("mr_idle_valid", 32'(instr_valid), 32'd0);
    start = 1;
    tick();
    start = 0;
    check("mr_refetch", 32'(instr), 32'hE003);

    // mixed ready pattern with periodic redirects, checked by the model
    for (int i = 0; i < 200; i++) begin
      instr_ready     = (i % 3) != 0;
      redirect_valid  = (i % 37) == 5;
      redirect_target = AW'(i * 7);
      tick();
    end
    redirect_valid = 0;
    instr_ready = 1;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
